// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the transmitter and the receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } uart_rx_state_t;

  localparam logic UART_IDLE_LEVEL = 1'b1;

  // Rounded-to-nearest clock cycles per bit for a given clock and baud rate.
  function automatic int clks_per_bit(input int f_clk, input int baud);
    return (f_clk + (baud / 2)) / baud;
  endfunction

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchroniser for an asynchronous single-bit input, with a selectable reset level.
module uart_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start/data/stop framing, mid-bit sampling, break handling after a framing error.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 87
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  SERIAL_RX,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  VALID,
  output logic                  FRAME_ERR,
  output logic                  BUSY,
  output uart_rx_state_t        state_dbg
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_MID = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [IW-1:0] IDX_MAX = IW'(DATA_WIDTH - 1);

  logic rx_s;

  uart_sync #(.RESET_VAL(UART_IDLE_LEVEL)) u_sync (
    .clk (CLK),
    .rst (RST),
    .d   (SERIAL_RX),
    .q   (rx_s)
  );

  uart_rx_state_t        state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  valid_q, valid_d;
  logic                  ferr_q, ferr_d;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    dout_d  = dout_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (rx_s != UART_IDLE_LEVEL) begin
          cnt_d   = '0;
          state_d = START;
        end
      end
      START: begin
        // A start bit that is high again by its centre was only a glitch.
        if (cnt_q == CNT_MID) begin
          cnt_d = '0;
          if (rx_s != UART_IDLE_LEVEL) begin
            idx_d   = '0;
            state_d = DATA;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DATA: begin
        if (cnt_q == CNT_MAX) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx_s;
          if (idx_q == IDX_MAX) begin
            state_d = STOP;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      STOP: begin
        if (cnt_q == CNT_MAX) begin
          cnt_d  = '0;
          dout_d = shift_q;
          if (rx_s == UART_IDLE_LEVEL) begin
            valid_d = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = BREAK;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      BREAK: begin
        // Hold off start detection until the line returns to idle.
        if (rx_s == UART_IDLE_LEVEL) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output contract: no ready/backpressure. VALID or FRAME_ERR is a single-cycle
  // registered pulse (never both); dout holds the word until the next frame ends.
  assign dout      = dout_q;
  assign VALID     = valid_q;
  assign FRAME_ERR = ferr_q;
  assign BUSY      = (state_q != IDLE);
  assign state_dbg = state_q;

endmodule
